// File: rtl/mov_sprite_ctrl_pkg.sv
// Shared types and default screen/sprite geometry for the moving-sprite path.
// The VGA timing and sprite memory blocks use the same constants.
package mov_sprite_ctrl_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int SPR_SIZE_DEF = 64;

  typedef enum logic {
    ST_STAND = 1'b0,
    ST_WALK  = 1'b1
  } walk_state_t;

  // Saturate a signed candidate position into [0, hi]
  function automatic logic [9:0] clamp_pos(input logic signed [10:0] p,
                                           input logic [9:0] hi);
    logic signed [10:0] hi_s;
    hi_s = $signed({1'b0, hi});
    if (p < 0) return 10'd0;
    if (p > hi_s) return hi;
    return p[9:0];
  endfunction

endpackage

// File: rtl/mov_sprite_ctrl_window_cmp.sv
// Combinational raster-vs-sprite window compare with local coordinate subtract.
// Shared with the static-sprite paths.
module sprite_window_cmp
  import mov_sprite_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int SPR_SIZE = SPR_SIZE_DEF
) (
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  output logic       hit,
  output logic [7:0] loc_x,
  output logic [7:0] loc_y
);

  localparam logic [9:0]  H_LIM = 10'(H_ACTIVE);
  localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);
  localparam logic [10:0] SPR_W = 11'(SPR_SIZE);

  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_h;
  logic        in_v;

  // Bit 10 is the borrow: set when the raster is left of / above the sprite
  assign dx = {1'b0, hcount} - {1'b0, pos_x};
  assign dy = {1'b0, vcount} - {1'b0, pos_y};

  assign in_h = (hcount < H_LIM) && !dx[10] && (dx < SPR_W);
  assign in_v = (vcount < V_LIM) && !dy[10] && (dy < SPR_W);

  assign hit   = in_h && in_v;
  assign loc_x = hit ? dx[7:0] : 8'd0;
  assign loc_y = hit ? dy[7:0] : 8'd0;

endmodule

// File: rtl/mov_sprite_ctrl.sv
// Moving-sprite control: per-frame position/facing/walk animation from buttons,
// and per-pixel sprite-local coordinates feeding the pattern memory address.
module mov_sprite_ctrl
  import mov_sprite_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int SPR_SIZE = SPR_SIZE_DEF,
  parameter int STEP     = 2,
  parameter int ANIM_DIV = 8,
  parameter int N_WALK   = 4,
  parameter int X_INIT   = 288,
  parameter int Y_INIT   = 208
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       frame_start,
  input  logic       enable,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [7:0] spr_x,
  output logic [7:0] spr_y,
  output logic [3:0] spr_char,
  output logic       spr_nx,
  output logic       spr_hit,
  output logic       spr_hit_d
);

  // state | meaning
  // STAND | no movement intent last update; char held at 0
  // WALK  | movement intent present (even if clamped); char cycles 1..N_WALK

  localparam int ANIM_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_DIV - 1);
  localparam logic [9:0]  X_MAX   = 10'(H_ACTIVE - SPR_SIZE);
  localparam logic [9:0]  Y_MAX   = 10'(V_ACTIVE - SPR_SIZE);
  localparam logic [9:0]  X_RST   = 10'(X_INIT);
  localparam logic [9:0]  Y_RST   = 10'(Y_INIT);
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic [3:0]  N_WALK_C = 4'(N_WALK);

  walk_state_t       state_q, state_d;
  logic [ANIM_W-1:0] anim_q, anim_d;
  logic [3:0]        char_q, char_d;
  logic              nx_q, nx_d;
  logic [9:0]        pos_x_q, pos_x_d;
  logic [9:0]        pos_y_q, pos_y_d;

  logic signed [10:0] h_int;
  logic signed [10:0] v_int;
  logic               moving;

  logic       win_hit;
  logic [7:0] win_x;
  logic [7:0] win_y;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_STAND;
      anim_q  <= '0;
      char_q  <= 4'd0;
      nx_q    <= 1'b0;
      pos_x_q <= X_RST;
      pos_y_q <= Y_RST;
    end else begin
      state_q <= state_d;
      anim_q  <= anim_d;
      char_q  <= char_d;
      nx_q    <= nx_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    anim_d  = anim_q;
    char_d  = char_q;
    nx_d    = nx_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    h_int   = 11'sd0;
    v_int   = 11'sd0;

    if (btn_left && !btn_right) h_int = -STEP_S;
    else if (btn_right && !btn_left) h_int = STEP_S;
    if (btn_up && !btn_down) v_int = -STEP_S;
    else if (btn_down && !btn_up) v_int = STEP_S;
    moving = (h_int != 11'sd0) || (v_int != 11'sd0);

    if (frame_start && enable) begin
      pos_x_d = clamp_pos($signed({1'b0, pos_x_q}) + h_int, X_MAX);
      pos_y_d = clamp_pos($signed({1'b0, pos_y_q}) + v_int, Y_MAX);
      if (btn_left && !btn_right) nx_d = 1'b1;
      else if (btn_right && !btn_left) nx_d = 1'b0;

      case (state_q)
        ST_STAND: begin
          if (moving) begin
            state_d = ST_WALK;
            char_d  = 4'd1;
            anim_d  = '0;
          end
        end
        ST_WALK: begin
          if (!moving) begin
            state_d = ST_STAND;
            char_d  = 4'd0;
            anim_d  = '0;
          end else if (anim_q == ANIM_LAST) begin
            anim_d = '0;
            char_d = (char_q >= N_WALK_C) ? 4'd1 : char_q + 4'd1;
          end else begin
            anim_d = anim_q + 1'b1;
          end
        end
        default: state_d = ST_STAND;
      endcase
    end
  end

  sprite_window_cmp #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .SPR_SIZE(SPR_SIZE)
  ) u_win (
    .hcount(hcount),
    .vcount(vcount),
    .pos_x (pos_x_q),
    .pos_y (pos_y_q),
    .hit   (win_hit),
    .loc_x (win_x),
    .loc_y (win_y)
  );

  // Raster outputs run every cycle; spr_hit_d lines up with the memory read data
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      spr_x     <= 8'd0;
      spr_y     <= 8'd0;
      spr_char  <= 4'd0;
      spr_nx    <= 1'b0;
      spr_hit   <= 1'b0;
      spr_hit_d <= 1'b0;
    end else begin
      spr_x     <= win_x;
      spr_y     <= win_y;
      spr_char  <= char_q;
      spr_nx    <= nx_q;
      spr_hit   <= win_hit;
      spr_hit_d <= spr_hit;
    end
  end

  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;

endmodule

// File: tb/tb_mov_sprite_ctrl.sv
// Self-checking bench for mov_sprite_ctrl: window vector table, directed
// movement/animation sequences, and randomized frames against a behavioural model.
module tb_mov_sprite_ctrl;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int SPR_SIZE = 64;
  localparam int STEP     = 2;
  localparam int ANIM_DIV = 8;
  localparam int N_WALK   = 4;
  localparam int X_INIT   = 288;
  localparam int Y_INIT   = 208;

  logic       clock = 1'b0;
  logic       resetn;
  logic [9:0] hcount, vcount;
  logic       frame_start, enable;
  logic       btn_left, btn_right, btn_up, btn_down;
  logic [9:0] pos_x, pos_y;
  logic [7:0] spr_x, spr_y;
  logic [3:0] spr_char;
  logic       spr_nx, spr_hit, spr_hit_d;

  int checks = 0;
  int failures = 0;

  // Behavioural model: position, facing, and length of the current walk run
  int m_px, m_py, m_nx, m_walk;

  always #5 clock = ~clock;

  mov_sprite_ctrl dut (
    .clock(clock), .resetn(resetn), .hcount(hcount), .vcount(vcount),
    .frame_start(frame_start), .enable(enable),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .pos_x(pos_x), .pos_y(pos_y), .spr_x(spr_x), .spr_y(spr_y),
    .spr_char(spr_char), .spr_nx(spr_nx), .spr_hit(spr_hit), .spr_hit_d(spr_hit_d)
  );

  typedef struct {
    int h; int v; int hit; int x; int y;
  } win_vec_t;

  win_vec_t wv[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int clampi(input int p, input int hi);
    if (p < 0) return 0;
    if (p > hi) return hi;
    return p;
  endfunction

  function automatic int m_char();
    if (m_walk == 0) return 0;
    return ((m_walk - 1) / ANIM_DIV) % N_WALK + 1;
  endfunction

  task automatic model_reset();
    m_px = X_INIT; m_py = Y_INIT; m_nx = 0; m_walk = 0;
  endtask

  task automatic model_frame(input bit l, input bit r, input bit u, input bit d);
    int hi, vi;
    hi = (l && !r) ? -STEP : ((r && !l) ? STEP : 0);
    vi = (u && !d) ? -STEP : ((d && !u) ? STEP : 0);
    m_px = clampi(m_px + hi, H_ACTIVE - SPR_SIZE);
    m_py = clampi(m_py + vi, V_ACTIVE - SPR_SIZE);
    if (l && !r) m_nx = 1;
    if (r && !l) m_nx = 0;
    if (hi != 0 || vi != 0) m_walk++;
    else m_walk = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_btn(input bit l, input bit r, input bit u, input bit d);
    btn_left = l; btn_right = r; btn_up = u; btn_down = d;
  endtask

  // One frame_start pulse, then one more clock so spr_char/spr_nx catch up
  task automatic do_frame(input bit l, input bit r, input bit u, input bit d, input bit en);
    set_btn(l, r, u, d);
    enable = en;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (en) model_frame(l, r, u, d);
    tick();
    check("pos_x", pos_x, m_px);
    check("pos_y", pos_y, m_py);
    check("spr_nx", spr_nx, m_nx);
    check("spr_char", spr_char, m_char());
  endtask

  task automatic raster_check(input int h, input int v);
    int eh, ex, ey;
    eh = (h < H_ACTIVE && v < V_ACTIVE && h >= m_px && h < m_px + SPR_SIZE &&
          v >= m_py && v < m_py + SPR_SIZE) ? 1 : 0;
    ex = eh ? ((h - m_px) & 255) : 0;
    ey = eh ? ((v - m_py) & 255) : 0;
    hcount = 10'(h);
    vcount = 10'(v);
    tick();
    check("spr_hit", spr_hit, eh);
    check("spr_x", spr_x, ex);
    check("spr_y", spr_y, ey);
  endtask

  initial begin
    int prev_hit;
    int h, v;

    wv[0] = '{288, 208, 1,  0,  0};
    wv[1] = '{351, 208, 1, 63,  0};
    wv[2] = '{352, 208, 0,  0,  0};
    wv[3] = '{287, 208, 0,  0,  0};
    wv[4] = '{288, 271, 1,  0, 63};
    wv[5] = '{288, 272, 0,  0,  0};
    wv[6] = '{351, 271, 1, 63, 63};
    wv[7] = '{300, 230, 1, 12, 22};
    wv[8] = '{288, 207, 0,  0,  0};
    wv[9] = '{700, 208, 0,  0,  0};

    resetn = 1'b0; frame_start = 1'b0; enable = 1'b1;
    hcount = 10'd288; vcount = 10'd208;
    set_btn(0, 0, 0, 0);
    model_reset();
    tick(); tick();
    check("rst_pos_x", pos_x, X_INIT);
    check("rst_pos_y", pos_y, Y_INIT);
    check("rst_spr_hit", spr_hit, 0);
    check("rst_spr_char", spr_char, 0);
    check("rst_spr_nx", spr_nx, 0);
    check("rst_spr_x", spr_x, 0);
    check("rst_spr_hit_d", spr_hit_d, 0);
    resetn = 1'b1;

    // Raster at the sprite origin right after reset
    tick();
    check("orig_hit", spr_hit, 1);
    check("orig_x", spr_x, 0);
    check("orig_y", spr_y, 0);
    check("orig_char", spr_char, 0);
    tick();
    check("orig_hit_d", spr_hit_d, 1);

    // Window vector table at the reset position
    prev_hit = 1;
    for (int i = 0; i < 10; i++) begin
      hcount = 10'(wv[i].h);
      vcount = 10'(wv[i].v);
      tick();
      check("tbl_hit", spr_hit, wv[i].hit);
      check("tbl_x", spr_x, wv[i].x);
      check("tbl_y", spr_y, wv[i].y);
      check("tbl_hit_d", spr_hit_d, prev_hit);
      prev_hit = wv[i].hit;
    end

    // Right for 3 frames
    for (int i = 0; i < 3; i++) do_frame(0, 1, 0, 0, 1);
    check("right3_pos_x", pos_x, 294);
    check("right3_char", spr_char, 1);
    check("right3_nx", spr_nx, 0);

    // Buttons without frame_start must not move anything
    set_btn(1, 0, 1, 0);
    tick(); tick();
    check("nofs_pos_x", pos_x, 294);

    // Reset to a clean start, then left for 40 frames
    resetn = 1'b0; #1; resetn = 1'b1;
    model_reset();
    for (int i = 0; i < 40; i++) do_frame(1, 0, 0, 0, 1);
    check("left40_pos_x", pos_x, 208);
    check("left40_nx", spr_nx, 1);
    check("left40_char", spr_char, 1);
    do_frame(0, 0, 0, 0, 1);
    check("release_char", spr_char, 0);

    // Walk into the left edge and stay clamped
    for (int i = 0; i < 103; i++) do_frame(1, 0, 0, 0, 1);
    check("near_edge_pos_x", pos_x, 2);
    for (int i = 0; i < 3; i++) do_frame(1, 0, 0, 0, 1);
    check("edge_pos_x", pos_x, 0);
    check("edge_nx", spr_nx, 1);
    check("edge_walk", spr_char != 4'd0, 1);

    // Window edges at the clamped position
    raster_check(63, m_py);
    check("edge63_x", spr_x, 63);
    raster_check(64, m_py);
    check("edge64_hit", spr_hit, 0);

    // Opposing buttons: no motion, facing kept, back to standing
    do_frame(1, 1, 0, 0, 1);
    check("both_pos_x", pos_x, 0);
    check("both_nx", spr_nx, 1);
    check("both_char", spr_char, 0);

    // Disabled: button ignored
    do_frame(0, 0, 0, 1, 0);
    check("dis_pos_y", pos_y, Y_INIT);

    // Randomized frames with raster probes around the sprite
    for (int it = 0; it < 250; it++) begin
      do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3) != 0);
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          h = $urandom_range(0, 1023);
          v = $urandom_range(0, 1023);
        end else begin
          h = m_px - 2 + $urandom_range(0, SPR_SIZE + 3);
          v = m_py - 2 + $urandom_range(0, SPR_SIZE + 3);
          if (h < 0) h = 0;
          if (v < 0) v = 0;
        end
        raster_check(h, v);
      end
    end

    // Asynchronous reset in the middle of a walk
    for (int i = 0; i < 5; i++) do_frame(0, 1, 0, 1, 1);
    hcount = 10'(m_px); vcount = 10'(m_py);
    tick();
    @(negedge clock);
    resetn = 1'b0;
    #1;
    model_reset();
    check("arst_pos_x", pos_x, X_INIT);
    check("arst_pos_y", pos_y, Y_INIT);
    check("arst_char", spr_char, 0);
    check("arst_hit", spr_hit, 0);
    check("arst_nx", spr_nx, 0);
    // frame_start during reset is ignored
    set_btn(1, 0, 1, 0);
    frame_start = 1'b1;
    tick(); tick();
    frame_start = 1'b0;
    set_btn(0, 0, 0, 0);
    resetn = 1'b1;
    check("arst_hold_pos_x", pos_x, X_INIT);
    raster_check(X_INIT + 5, Y_INIT + 7);
    do_frame(0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
